// File: rtl/seg7_scan_driver_if.sv
// CPU-side store/read-back bus of the seven-segment display controller.
// The I/O decoder (master) forwards store strobes and data; the driver (slave) returns its registers.
interface seg7_scan_driver_if;
    logic        wr_value;
    logic        wr_ctrl;
    logic [31:0] wr_data;
    logic [31:0] value_q;
    logic [16:0] ctrl_q;

    modport master (output wr_value, wr_ctrl, wr_data, input value_q, ctrl_q);
    modport slave  (input wr_value, wr_ctrl, wr_data, output value_q, ctrl_q);
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver for a common-anode display.
// Holds a 32-bit hex value and a control word; all display pins are active-low and registered.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    bus,
    output logic [7:0]           AN,
    output logic [6:0]           A2G,
    output logic                 DP
);

    localparam logic [19:0] CNT_LAST = 20'(REFRESH_DIV - 1);
    localparam logic [19:0] GHOST_C  = 20'(GHOST);

    logic [31:0] value_q, value_d;
    logic [16:0] ctrl_q, ctrl_d;
    logic [19:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  a2g_q, a2g_d;
    logic        dp_q, dp_d;

    logic [7:0]  dig_en;
    logic [7:0]  dp_en;
    logic [3:0]  nibble;
    logic [31:0] upper;
    logic        lz_blank;
    logic        blank;

    // Active-low abcdefg pattern, a in bit 6.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        value_d = bus.wr_value ? bus.wr_data : value_q;
        ctrl_d  = bus.wr_ctrl  ? bus.wr_data[16:0] : ctrl_q;

        cnt_d = cnt_q + 20'd1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        dig_en = ctrl_q[7:0];
        dp_en  = ctrl_q[15:8];
        nibble = value_q[{idx_q, 2'b00} +: 4];
        // Digit idx is a leading zero when it and every nibble above it are zero.
        upper    = value_q >> {idx_q, 2'b00};
        lz_blank = ctrl_q[16] && (idx_q != 3'd0) && (upper == 32'd0);
        blank    = !dig_en[idx_q] || (cnt_q < GHOST_C) || lz_blank;

        an_d  = 8'hFF;
        a2g_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(8'b1 << idx_q);
            a2g_d = hex7(nibble);
            dp_d  = ~dp_en[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            ctrl_q  <= 17'h000FF;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 8'hFF;
            a2g_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            value_q <= value_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            a2g_q   <= a2g_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.value_q = value_q;
    assign bus.ctrl_q  = ctrl_q;
    assign AN  = an_q;
    assign A2G = a2g_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-cycle slot and 2 ghost cycles.
// pos counts rising edges since reset release; the pins at pos show scan position pos.
module tb_seg7_scan_driver;
    localparam int RD = 8;
    localparam int GH = 2;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S3 = 7'b0000110;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b1100000, SC = 7'b0110001, SD = 7'b1000010;
    localparam logic [6:0] SE = 7'b0110000, SF = 7'b0111000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] AN;
    logic [6:0] A2G;
    logic       DP;

    int vectors     = 0;
    int miscompares = 0;
    int pos         = -1;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.REFRESH_DIV(RD), .GHOST(GH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .AN  (AN),
        .A2G (A2G),
        .DP  (DP)
    );

    task automatic tick();
        @(posedge clk);
        pos++;
        @(negedge clk);
    endtask

    task automatic to_pos(input int target);
        while ((pos % 64) != target) tick();
    endtask

    task automatic write(input logic wv, input logic wc, input logic [31:0] d);
        bus.wr_value = wv;
        bus.wr_ctrl  = wc;
        bus.wr_data  = d;
        tick();
        bus.wr_value = 1'b0;
        bus.wr_ctrl  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ea; logic [6:0] es; logic ed;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({AN, A2G, DP} !== {8'hFF, 7'h7F, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_pins got AN=%h A2G=%b DP=%b want AN=ff A2G=1111111 DP=1", AN, A2G, DP);
        end
        vectors++;
        if (bus.value_q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_value got %h want 00000000", bus.value_q);
        end
        vectors++;
        if (bus.ctrl_q !== 17'h000FF) begin
            miscompares++;
            $display("FAIL reset_ctrl got %h want 000ff", bus.ctrl_q);
        end
        rst = 1'b1;
        pos = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (pos % 8 >= 2) begin
                ea = (pos < 8) ? 8'hFE : 8'hFD;
                es = S0;
            end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL release_scan pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
    endtask

    task automatic test_full_scan();
        logic [7:0] an_tab [8];
        logic [6:0] seg_tab [8];
        logic [7:0] ea; logic [6:0] es; logic ed;
        an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        seg_tab = '{SF, SE, SD, SC, SB, SA, S9, S8};
        write(1'b1, 1'b0, 32'h89ABCDEF);
        to_pos(63);
        for (int i = 0; i < 64; i++) begin
            int s;
            tick();
            s = (pos / 8) % 8;
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (pos % 8 >= 2) begin
                ea = an_tab[s];
                es = seg_tab[s];
            end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL full_scan pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
    endtask

    task automatic test_ctrl_masks();
        logic [7:0] an_tab [4];
        logic [6:0] seg_tab [4];
        logic [7:0] ea; logic [6:0] es; logic ed;
        an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        seg_tab = '{SF, SE, SD, SC};
        write(1'b0, 1'b1, 32'h0000810F);
        to_pos(63);
        for (int i = 0; i < 64; i++) begin
            int s;
            tick();
            s = (pos / 8) % 8;
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (pos % 8 >= 2 && s < 4) begin
                ea = an_tab[s];
                es = seg_tab[s];
                ed = (s == 0) ? 1'b0 : 1'b1;
            end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL ctrl_masks pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
    endtask

    task automatic test_lzb();
        logic [7:0] ea; logic [6:0] es; logic ed;
        write(1'b1, 1'b0, 32'h000000A0);
        write(1'b0, 1'b1, 32'h000100FF);
        to_pos(63);
        for (int i = 0; i < 64; i++) begin
            int s;
            tick();
            s = (pos / 8) % 8;
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (pos % 8 >= 2 && s == 0) begin ea = 8'hFE; es = S0; end
            if (pos % 8 >= 2 && s == 1) begin ea = 8'hFD; es = SA; end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL lzb_a0 pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
        write(1'b1, 1'b0, 32'h00000000);
        to_pos(63);
        for (int i = 0; i < 64; i++) begin
            tick();
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (pos % 8 >= 2 && (pos / 8) % 8 == 0) begin ea = 8'hFE; es = S0; end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL lzb_zero pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
    endtask

    task automatic test_simul_writes();
        logic [7:0] ea; logic [6:0] es; logic ed;
        write(1'b1, 1'b0, 32'h89ABCDEF);
        write(1'b0, 1'b1, 32'h000000FF);
        to_pos(27);
        vectors++;
        if ({AN, A2G, DP} !== {8'hF7, SC, 1'b1}) begin
            miscompares++;
            $display("FAIL simul_before got AN=%h A2G=%b DP=%b want AN=f7 A2G=%b DP=1", AN, A2G, DP, SC);
        end
        bus.wr_value = 1'b1;
        bus.wr_ctrl  = 1'b1;
        bus.wr_data  = 32'h000138FF;
        tick();
        bus.wr_value = 1'b0;
        bus.wr_ctrl  = 1'b0;
        vectors++;
        if ({AN, A2G, DP} !== {8'hF7, SC, 1'b1}) begin
            miscompares++;
            $display("FAIL simul_write_edge got AN=%h A2G=%b DP=%b want AN=f7 A2G=%b DP=1", AN, A2G, DP, SC);
        end
        vectors++;
        if (bus.value_q !== 32'h000138FF) begin
            miscompares++;
            $display("FAIL simul_value got %h want 000138ff", bus.value_q);
        end
        vectors++;
        if (bus.ctrl_q !== 17'h138FF) begin
            miscompares++;
            $display("FAIL simul_ctrl got %h want 138ff", bus.ctrl_q);
        end
        while (pos % 64 < 47) begin
            int s;
            tick();
            s = (pos / 8) % 8;
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (s == 3) begin ea = 8'hF7; es = S3; ed = 1'b0; end
            if (s == 4 && pos % 8 >= 2) begin ea = 8'hEF; es = S1; ed = 1'b0; end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL simul_after pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] ea; logic [6:0] es; logic ed;
        write(1'b1, 1'b0, 32'h89ABCDEF);
        write(1'b0, 1'b1, 32'h000000FF);
        to_pos(43);
        vectors++;
        if ({AN, A2G, DP} !== {8'hDF, SA, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_before got AN=%h A2G=%b DP=%b want AN=df A2G=%b DP=1", AN, A2G, DP, SA);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({AN, A2G, DP} !== {8'hFF, 7'h7F, 1'b1}) begin
            miscompares++;
            $display("FAIL midrst_async got AN=%h A2G=%b DP=%b want AN=ff A2G=1111111 DP=1", AN, A2G, DP);
        end
        vectors++;
        if (bus.value_q !== 32'h0 || bus.ctrl_q !== 17'h000FF) begin
            miscompares++;
            $display("FAIL midrst_regs got value=%h ctrl=%h want 00000000 000ff", bus.value_q, bus.ctrl_q);
        end
        @(negedge clk);
        rst = 1'b1;
        pos = -1;
        for (int i = 0; i < 11; i++) begin
            tick();
            ea = 8'hFF; es = 7'h7F; ed = 1'b1;
            if (pos % 8 >= 2) begin
                ea = (pos < 8) ? 8'hFE : 8'hFD;
                es = S0;
            end
            vectors++;
            if ({AN, A2G, DP} !== {ea, es, ed}) begin
                miscompares++;
                $display("FAIL midrst_restart pos=%0d got AN=%h A2G=%b DP=%b want AN=%h A2G=%b DP=%b",
                         pos, AN, A2G, DP, ea, es, ed);
            end
        end
    endtask

    initial begin
        bus.wr_value = 1'b0;
        bus.wr_ctrl  = 1'b0;
        bus.wr_data  = 32'h0;
        test_reset();
        test_full_scan();
        test_ctrl_masks();
        test_lzb();
        test_simul_writes();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Memory-mapped eight-digit seven-segment display controller that sits directly downstream of the data-memory I/O decoder. The decoder forwards CPU store strobes and store data to it. The block holds a 32-bit display value and a control word, and time-multiplexes the eight hex digits onto the board's common-anode display. All display outputs are active-low and registered.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays selected (1 kHz per digit at 100 MHz); legal range 4..2^20.
- GHOST, 4: cycles at the start of each digit slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_value  input  1  store strobe for the value register.
- wr_ctrl  input  1  store strobe for the control register.
- wr_data  input  32  store data from the CPU.
- value_q  output  32  current value register (CPU read-back).
- ctrl_q  output  17  current control register: [7:0] digit enable, [15:8] decimal-point enable, [16] leading-zero blank (LZB).
- AN  output  8  anode select, active-low; AN[i] drives digit i, and digit 0 is the rightmost digit (value[3:0]).
- A2G  output  7  segments, active-low; A2G[6]=a … A2G[0]=g.
- DP  output  1  decimal point, active-low.

## Operation
- Registers:
  - wr_value=1 loads value_q ← wr_data.
  - wr_ctrl=1 loads ctrl_q ← wr_data[16:0].
  - Both strobes may be asserted in the same cycle; both loads occur.
- Scan state:
  - 20-bit refresh counter cnt and 3-bit digit index idx.
  - cnt counts 0..REFRESH_DIV-1. When it reaches REFRESH_DIV-1, it returns to 0 and idx increments, wrapping 7→0.
- Blank condition for digit idx. The digit is blanked if any of the following holds:
  - ctrl_q[idx]=0.
  - cnt < GHOST.
  - LZB=1, idx>0, and every nibble of value_q from position idx up to 7 is zero.
  - Digit 0 is never blanked by LZB.
- Output when the digit is not blanked:
  - AN = ~(8'b1 << idx).
  - A2G = hex pattern of value_q[4*idx+3 : 4*idx].
  - DP = ~ctrl_q[8+idx].
- Output when the digit is blanked: AN=8'hFF, A2G=7'h7F, DP=1.
- Hex patterns for A2G (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Writes never disturb cnt or idx.

## Timing
- Reset (rst=0, asynchronous) sets:
  - value_q=0, ctrl_q=17'h000FF (all digits enabled, no DP, LZB off), cnt=0, idx=0.
  - AN=8'hFF, A2G=7'h7F, DP=1.
- Reset release: scanning starts on the first rising edge with rst=1.
- AN, A2G and DP are registered. They reflect the cnt, idx, value_q and ctrl_q from the previous cycle, so there is 1-cycle latency from the state to the pins.
- A write on edge k updates value_q/ctrl_q at edge k; the pins reflect the new data at edge k+1.
- Each digit slot is REFRESH_DIV cycles long: GHOST blank cycles, then REFRESH_DIV-GHOST lit cycles. A full frame is 8·REFRESH_DIV cycles.
- Reset asserted mid-scan clears the outputs immediately, without waiting for a clock edge. The next scan restarts at digit 0 with cnt=0.

## Test plan
- Reset behaviour (REFRESH_DIV=8, GHOST=2):
  - Hold rst=0 → AN=FF, A2G=7F, DP=1, value_q=0, ctrl_q=000FF.
  - Release rst → digit 0 shows "0" (A2G=0000001, AN=FE) during cnt 2..7. Digit 1 shows "0" with AN=FD in the next slot.
- Full-value scan: write value 32'h89ABCDEF → over one frame AN walks FE,FD,…,7F, and A2G cycles through the F,E,d,C,b,A,9,8 patterns. Each slot has exactly 2 blank cycles followed by 6 lit cycles.
- Control masks: write ctrl 17'h0_81_0F → digits 4–7 are always blanked. DP=0 only while digit 0 is lit; digit 7 stays blanked despite its DP bit being set.
- Leading-zero blank: value 32'h0000_00A0 with ctrl 17'h1_00_FF → only digits 0 ("0") and 1 ("A") light. Value 0 with LZB → only digit 0 lights, showing "0".
- Simultaneous writes mid-slot: assert wr_value and wr_ctrl in the same cycle while digit 3 is lit → both registers update. The pins change one edge later, and cnt/idx are undisturbed.
- Reset mid-scan: assert rst at idx=5, cnt=4 → outputs go blank with no clock edge. After release, the scan restarts at digit 0 with value_q=0.
